// File: rtl/simon_dec_if.sv
// Handshake and data bundle between a Simon32/64 decrypt master and simon_dec_core.
interface simon_dec_if;
  logic [31:0][15:0] key;
  logic              key_ready;
  logic              start;
  logic [31:0]       ciphertext;
  logic              busy;
  logic              done;
  logic [31:0]       plaintext;

  modport master (
    output key, key_ready, start, ciphertext,
    input  busy, done, plaintext
  );

  modport slave (
    input  key, key_ready, start, ciphertext,
    output busy, done, plaintext
  );
endinterface

// File: rtl/simon_dec_core.sv
// Iterative Simon32/64 decryption core: Feistel rounds in reverse key order, round 31 first.
// Define SIMON_DEC_TWO_ROUND_EN to run two cascaded rounds per clock (16-cycle latency).
module simon_dec_core (
  input  logic          clk,
  input  logic          rst,
  simon_dec_if.slave    bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [4:0]  rc_q, rc_d;
  logic [15:0] x_q, x_d;
  logic [15:0] y_q, y_d;
  logic [31:0] pt_q, pt_d;

  logic [15:0] r1_x, r1_y;
  logic [15:0] nx, ny;
  logic        last_step;
  logic [4:0]  rc_step;

  function automatic logic [15:0] simon_f(input logic [15:0] v);
    return ({v[14:0], v[15]} & {v[7:0], v[15:8]}) ^ {v[13:0], v[15:14]};
  endfunction

  // Decryption round: (x, y) -> (y, x ^ f(y) ^ k).
  always_comb begin
    r1_x = y_q;
    r1_y = x_q ^ simon_f(y_q) ^ bus.key[rc_q];
`ifdef SIMON_DEC_TWO_ROUND_EN
    nx        = r1_y;
    ny        = r1_x ^ simon_f(r1_y) ^ bus.key[rc_q - 5'd1];
    last_step = (rc_q == 5'd1);
    rc_step   = 5'd2;
`else
    nx        = r1_x;
    ny        = r1_y;
    last_step = (rc_q == 5'd0);
    rc_step   = 5'd1;
`endif
  end

  // NOTE: every signal assigned here gets a default first, so no path leaves one unassigned and infers a latch.
  always_comb begin
    state_d = state_q;
    rc_d    = rc_q;
    x_d     = x_q;
    y_d     = y_q;
    pt_d    = pt_q;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        if (bus.start && bus.key_ready) begin
          state_d = ST_RUN;
          x_d     = bus.ciphertext[31:16];
          y_d     = bus.ciphertext[15:0];
          rc_d    = 5'd31;
        end
      end
      ST_RUN: begin
        x_d  = nx;
        y_d  = ny;
        rc_d = rc_q - rc_step;
        if (last_step) begin
          state_d = ST_DONE;
          pt_d    = {nx, ny};
          rc_d    = 5'd0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      rc_q    <= 5'd0;
      x_q     <= 16'h0;
      y_q     <= 16'h0;
      pt_q    <= 32'h0;
    end else begin
      state_q <= state_d;
      rc_q    <= rc_d;
      x_q     <= x_d;
      y_q     <= y_d;
      pt_q    <= pt_d;
    end
  end

  // Status decodes straight from state so an async reset clears them without waiting for a clock.
  assign bus.busy      = (state_q == ST_RUN);
  assign bus.done      = (state_q == ST_DONE);
  assign bus.plaintext = pt_q;

endmodule

// File: tb/tb_simon_dec_core.sv
// Directed bench for simon_dec_core: known answer, round trips against a software Simon model, handshake corners.
module tb_simon_dec_core;

`ifdef SIMON_DEC_TWO_ROUND_EN
  localparam int LAT = 16;
`else
  localparam int LAT = 32;
`endif

  logic clk;
  logic rst;
  simon_dec_if bus ();

  simon_dec_core dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic [15:0] mk [32];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] rotl(input logic [15:0] v, input int s);
    return (v << s) | (v >> (16 - s));
  endfunction

  function automatic logic [15:0] rotr(input logic [15:0] v, input int s);
    return (v >> s) | (v << (16 - s));
  endfunction

  function automatic logic [15:0] fmod(input logic [15:0] v);
    return (rotl(v, 1) & rotl(v, 8)) ^ rotl(v, 2);
  endfunction

  // Simon32/64 key schedule; keytext[63:48] is key[0].
  task automatic set_keytext(input logic [63:0] kt);
    logic [63:0] z;
    logic [15:0] tmp;
    z = 64'h19C3522FB386A45F;
    mk[0] = kt[63:48];
    mk[1] = kt[47:32];
    mk[2] = kt[31:16];
    mk[3] = kt[15:0];
    for (int i = 4; i < 32; i++) begin
      tmp   = rotr(mk[i-1], 3) ^ mk[i-3];
      tmp   = tmp ^ rotr(tmp, 1);
      mk[i] = ~mk[i-4] ^ tmp ^ {15'd0, z[i-4]} ^ 16'd3;
    end
    for (int i = 0; i < 32; i++) bus.key[i] = mk[i];
  endtask

  function automatic logic [31:0] enc(input logic [31:0] pt);
    logic [15:0] x, y, t;
    x = pt[31:16];
    y = pt[15:0];
    for (int i = 0; i < 32; i++) begin
      t = x;
      x = y ^ fmod(x) ^ mk[i];
      y = t;
    end
    return {x, y};
  endfunction

  // Starts one block, optionally spams start during RUN, and checks latency, pulse count and result.
  task automatic run_block(input logic [31:0] ct, input logic [31:0] exp, input string tag, input bit noise);
    int first, ndone;
    @(negedge clk);
    bus.ciphertext = ct;
    bus.start      = 1'b1;
    @(negedge clk);
    bus.start      = 1'b0;
    bus.ciphertext = ~ct;
    first = -1;
    ndone = 0;
    for (int n = 1; n <= LAT + 4; n++) begin
      if (bus.done) begin
        ndone++;
        if (first < 0) first = n;
      end
      if (bus.busy && bus.done) ndone += 100;
      if (noise && bus.busy) begin
        bus.start      = n[0];
        bus.ciphertext = $urandom;
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
    end
    bus.start = 1'b0;
    check({tag, "_lat"}, first, LAT + 1);
    check({tag, "_ndone"}, ndone, 1);
    check({tag, "_pt"}, bus.plaintext, exp);
  endtask

  initial begin
    logic [31:0] pt, ct_b, exp_b;
    int n, m, idle_bad;

    rst            = 1'b0;
    bus.start      = 1'b0;
    bus.key_ready  = 1'b0;
    bus.ciphertext = 32'h0;
    bus.key        = '0;
    #3;
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_pt", bus.plaintext, 32'h0);
    @(negedge clk);
    rst = 1'b1;

    // Known answer
    set_keytext(64'h0100_0908_1110_1918);
    bus.key_ready = 1'b1;
    run_block(32'hc69b_e9bb, 32'h6565_6877, "kat", 1'b0);

    // Round trips at the extreme blocks and keys
    for (int k = 0; k < 2; k++) begin
      set_keytext(k == 0 ? 64'h0 : 64'hFFFF_FFFF_FFFF_FFFF);
      run_block(enc(32'h0000_0000), 32'h0000_0000, "rt_zero", 1'b0);
      run_block(enc(32'hFFFF_FFFF), 32'hFFFF_FFFF, "rt_ones", 1'b0);
    end

    // Start pulses during RUN are ignored
    set_keytext(64'h0100_0908_1110_1918);
    run_block(32'hc69b_e9bb, 32'h6565_6877, "ign", 1'b1);

    // Start without key_ready stays idle
    bus.key_ready = 1'b0;
    @(negedge clk);
    bus.ciphertext = 32'h1234_5678;
    bus.start      = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    check("nokey_busy", bus.busy, 0);
    repeat (LAT + 2) @(negedge clk);
    check("nokey_done", bus.done, 0);
    check("nokey_pt", bus.plaintext, 32'h6565_6877);
    bus.key_ready = 1'b1;

    // Back-to-back via start held in DONE
    pt    = 32'hA5A5_0F0F;
    ct_b  = enc(pt);
    exp_b = pt;
    @(negedge clk);
    bus.ciphertext = 32'hc69b_e9bb;
    bus.start      = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    n = 1;
    while (!bus.done && n < LAT + 10) begin
      @(negedge clk);
      n++;
    end
    check("b2b_lat1", n, LAT + 1);
    check("b2b_pt1", bus.plaintext, 32'h6565_6877);
    bus.ciphertext = ct_b;
    bus.start      = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    check("b2b_busy", bus.busy, 1);
    check("b2b_done_low", bus.done, 0);
    m = 1;
    while (!bus.done && m < LAT + 10) begin
      @(negedge clk);
      m++;
    end
    check("b2b_gap", m, LAT + 1);
    check("b2b_pt2", bus.plaintext, exp_b);

    // Asynchronous reset mid-run
    @(negedge clk);
    bus.ciphertext = 32'hc69b_e9bb;
    bus.start      = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (LAT / 3) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("mid_rst_busy", bus.busy, 0);
    check("mid_rst_done", bus.done, 0);
    check("mid_rst_pt", bus.plaintext, 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    run_block(32'hc69b_e9bb, 32'h6565_6877, "post_rst", 1'b0);

    // Idle stability
    idle_bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.plaintext !== 32'h6565_6877 || bus.done !== 1'b0) idle_bad++;
    end
    check("idle_hold", idle_bad, 0);

    // Random keys and blocks against the software model
    for (int r = 0; r < 100; r++) begin
      set_keytext({$urandom, $urandom});
      pt = $urandom;
      run_block(enc(pt), pt, "rand", 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
